patch_control_unit: RTL and testbench



---
 rtl/patch_pkg.sv | 45 ++++
 rtl/patch_cfg_shift.sv | 42 ++++
 rtl/patch_control_unit.sv | 125 ++++++++++++
 tb/tb_patch_control_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/patch_pkg.sv
// Shared types and config-word layout for the observe/control patch unit.
// Latency: n/a (types, parameters and constant functions only).
// Backpressure: n/a.
package patch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ARMED  = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Default field widths; the top recomputes the layout from its own parameters.
  localparam int OBS_W_DEF  = 8;
  localparam int CTRL_W_DEF = 8;
  localparam int HOLD_W_DEF = 8;

  // Config word, LSB first: match_mask, match_val, ovr_mask, ovr_val, hold.
  function automatic int cfg_width(input int obs_w, input int ctrl_w, input int hold_w);
    return 2 * obs_w + 2 * ctrl_w + hold_w;
  endfunction

  function automatic int off_match_mask();
    return 0;
  endfunction

  function automatic int off_match_val(input int obs_w);
    return obs_w;
  endfunction

  function automatic int off_ovr_mask(input int obs_w);
    return 2 * obs_w;
  endfunction

  function automatic int off_ovr_val(input int obs_w, input int ctrl_w);
    return 2 * obs_w + ctrl_w;
  endfunction

  function automatic int off_hold(input int obs_w, input int ctrl_w);
    return 2 * obs_w + 2 * ctrl_w;
  endfunction

  localparam int CFG_W_DEF = cfg_width(OBS_W_DEF, CTRL_W_DEF, HOLD_W_DEF);

endpackage

// File: rtl/patch_cfg_shift.sv
// Serial config shift register (LSB first) with accepted-bit counter.
// Latency: bit visible in cfg_word one edge after acceptance; load_done is combinational on the last bit.
// Backpressure: none; every shift_en cycle accepts one bit, restart makes that bit bit 0.
module patch_cfg_shift #(
  parameter int CFG_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             bit_in,
  output logic [CFG_W-1:0] cfg_word,
  output logic             load_done
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] base_cnt;

  // A restart discards any partial count so the incoming bit becomes bit 0.
  always_comb begin
    base_cnt  = restart ? '0 : bit_cnt;
    load_done = shift_en && (base_cnt == CNT_W'(CFG_W - 1));
  end

  // Shift new bits in at the MSB so the first bit ends up at bit 0 after CFG_W shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_word <= '0;
      bit_cnt  <= '0;
    end else if (shift_en) begin
      if (restart) begin
        cfg_word <= {bit_in, {(CFG_W-1){1'b0}}};
      end else begin
        cfg_word <= {bit_in, cfg_word[CFG_W-1:1]};
      end
      bit_cnt <= load_done ? '0 : base_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/patch_control_unit.sv
// Patch consumer: loads serial config, arms on it, overrides control signals for hold cycles on match.
// Latency: state changes one edge after cfg/match; ctrl_out combinational (one cycle if PATCH_CTRL_OUT_REG_EN).
// Backpressure: none; cfg_valid in ARMED/ACTIVE aborts the patch and restarts loading.
module patch_control_unit
  import patch_pkg::*;
#(
  parameter int OBS_W  = 8,
  parameter int CTRL_W = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  input  logic              cfg_data,
  input  logic [OBS_W-1:0]  observe,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              armed,
  output logic              patch_active
);

  localparam int CFG_W = cfg_width(OBS_W, CTRL_W, HOLD_W);
  localparam int O_MM  = off_match_mask();
  localparam int O_MV  = off_match_val(OBS_W);
  localparam int O_OM  = off_ovr_mask(OBS_W);
  localparam int O_OV  = off_ovr_val(OBS_W, CTRL_W);
  localparam int O_HD  = off_hold(OBS_W, CTRL_W);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [CFG_W-1:0]    cfg_word;
  logic                load_done;
  logic                abort;
  logic                match;
  logic [OBS_W-1:0]    match_mask, match_val;
  logic [CTRL_W-1:0]   ovr_mask, ovr_val, ctrl_patched;
  logic [HOLD_W-1:0]   hold;

  assign match_mask = cfg_word[O_MM +: OBS_W];
  assign match_val  = cfg_word[O_MV +: OBS_W];
  assign ovr_mask   = cfg_word[O_OM +: CTRL_W];
  assign ovr_val    = cfg_word[O_OV +: CTRL_W];
  assign hold       = cfg_word[O_HD +: HOLD_W];

  // Any config bit while a configuration is live throws that configuration away.
  assign abort = cfg_valid && ((state == ST_ARMED) || (state == ST_ACTIVE));
  assign match = ((observe ^ match_val) & match_mask) == '0;

  patch_cfg_shift #(.CFG_W(CFG_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (cfg_valid),
    .restart   (abort),
    .bit_in    (cfg_data),
    .cfg_word  (cfg_word),
    .load_done (load_done)
  );

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next state: loading, arming, timed (or sticky when hold is 0) override window.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) state_nxt = load_done ? ST_ARMED : ST_LOAD;
      end
      ST_LOAD: begin
        if (load_done) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (cfg_valid) begin
          state_nxt    = load_done ? ST_ARMED : ST_LOAD;
          hold_cnt_nxt = '0;
        end else if (match) begin
          state_nxt    = ST_ACTIVE;
          hold_cnt_nxt = hold;
        end
      end
      ST_ACTIVE: begin
        if (cfg_valid) begin
          state_nxt    = load_done ? ST_ARMED : ST_LOAD;
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_W'(1)) begin
          state_nxt    = ST_ARMED;
          hold_cnt_nxt = '0;
        end else if (hold_cnt != '0) begin
          hold_cnt_nxt = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  assign armed        = (state == ST_ARMED);
  assign patch_active = (state == ST_ACTIVE);
  assign ctrl_patched = (ctrl_in & ~ovr_mask) | (ovr_val & ovr_mask);

`ifdef PATCH_CTRL_OUT_REG_EN
  // Registered override output; apply, release and pass-through all lag one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_out <= '0;
    end else begin
      ctrl_out <= patch_active ? ctrl_patched : ctrl_in;
    end
  end
`else
  assign ctrl_out = patch_active ? ctrl_patched : ctrl_in;
`endif

endmodule

// File: tb/tb_patch_control_unit.sv
// Directed bench for patch_control_unit: load, no-trigger, timed/sticky/re-triggered windows, abort, reset.
// Latency: checks sampled 3 time units after each rising edge.
// Backpressure: n/a.
module tb_patch_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_data;
  logic [7:0] observe;
  logic [7:0] ctrl_in;
  logic [7:0] ctrl_out;
  logic       armed;
  logic       patch_active;

  int total  = 0;
  int passed = 0;

  // Bench-side expectations, set by hand in the directed sequence.
  logic       exp_armed  = 1'b0;
  logic       exp_active = 1'b0;
  logic [7:0] m_ovm = 8'h00;
  logic [7:0] m_ovv = 8'h00;
  logic [7:0] cur_exp_comb;

  assign cur_exp_comb = exp_active ? ((ctrl_in & ~m_ovm) | (m_ovv & m_ovm)) : ctrl_in;

`ifdef PATCH_CTRL_OUT_REG_EN
  logic [7:0] exp_reg;
  // Expected registered output: last cycle's expected combinational value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_reg <= 8'h00;
    else        exp_reg <= cur_exp_comb;
  end
`endif

  always #5 clk = ~clk;

  patch_control_unit #(.OBS_W(8), .CTRL_W(8), .HOLD_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .observe      (observe),
    .ctrl_in      (ctrl_in),
    .ctrl_out     (ctrl_out),
    .armed        (armed),
    .patch_active (patch_active)
  );

  task automatic chk(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
  endtask

  task automatic chk_state(input string tag);
    chk(tag, "armed", {7'b0, armed}, {7'b0, exp_armed});
    chk(tag, "patch_active", {7'b0, patch_active}, {7'b0, exp_active});
`ifdef PATCH_CTRL_OUT_REG_EN
    chk(tag, "ctrl_out", ctrl_out, exp_reg);
`else
    chk(tag, "ctrl_out", ctrl_out, cur_exp_comb);
`endif
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  // Shift a 40-bit word in LSB first; optional idle cycle after every bit.
  task automatic load_cfg(input string tag, input logic [39:0] word, input bit gaps);
    for (int i = 0; i < 40; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = word[i];
      nxt();
      cfg_valid  = 1'b0;
      exp_active = 1'b0;
      exp_armed  = (i == 39);
      if (i == 0 || i >= 38) begin
        #1;
        chk_state($sformatf("%s_bit%0d", tag, i));
      end
      if (gaps && i < 39) nxt();
    end
    m_ovm = word[23:16];
    m_ovv = word[31:24];
  endtask

  // {hold, ovr_val, ovr_mask, match_val, match_mask}
  localparam logic [39:0] CFG_H3  = {8'd3, 8'h01, 8'h81, 8'h05, 8'h0F};
  localparam logic [39:0] CFG_H0  = {8'd0, 8'h01, 8'h81, 8'h05, 8'h0F};
  localparam logic [39:0] CFG_MM0 = {8'd1, 8'hF0, 8'hF0, 8'h00, 8'h00};

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = 1'b0;
    observe   = 8'hA4;
    ctrl_in   = 8'h5A;
    #3;
    chk_state("reset");

    nxt();
    rst_n   = 1'b1;
    ctrl_in = 8'hFF;

    // Plain load, observe does not match.
    load_cfg("load_h3", CFG_H3, 1'b0);

    // Armed without match: output follows ctrl_in.
    for (int k = 0; k < 5; k++) begin
      nxt();
      ctrl_in = k[0] ? 8'h3C : 8'hFF;
      #1;
      chk_state($sformatf("nomatch%0d", k));
    end

    // Match for one sample -> exactly 3 active cycles.
    ctrl_in = 8'hFF;
    observe = 8'hA5;
    nxt();
    observe    = 8'hA4;
    exp_active = 1'b1;
    exp_armed  = 1'b0;
    #1; chk_state("win_c1");
    nxt(); #1; chk_state("win_c2");
    nxt(); #1; chk_state("win_c3");
    nxt();
    exp_active = 1'b0;
    exp_armed  = 1'b1;
    #1; chk_state("win_end");
    nxt(); #1; chk_state("win_after");

    // match_mask = 0: triggers immediately and re-triggers after one armed cycle.
    ctrl_in = 8'h0F;
    load_cfg("load_mm0", CFG_MM0, 1'b0);
    nxt(); exp_active = 1'b1; exp_armed = 1'b0; #1; chk_state("mm0_act1");
    nxt(); exp_active = 1'b0; exp_armed = 1'b1; #1; chk_state("mm0_arm");
    nxt(); exp_active = 1'b1; exp_armed = 1'b0; #1; chk_state("mm0_act2");
    nxt(); exp_active = 1'b0; exp_armed = 1'b1; #1; chk_state("mm0_arm2");

    // hold = 0: sticky window, then abort by a config bit.
    ctrl_in = 8'hFF;
    observe = 8'hA4;
    load_cfg("load_h0", CFG_H0, 1'b0);
    observe = 8'hA5;
    nxt();
    observe    = 8'hA4;
    exp_active = 1'b1;
    exp_armed  = 1'b0;
    #1; chk_state("h0_trig");
    repeat (120) nxt();
    #1; chk_state("h0_sticky");

    // Abort plus reload with an idle cycle between every bit.
    load_cfg("load_gap", CFG_H3, 1'b1);

    // Reset asserted mid-patch.
    observe = 8'hA5;
    nxt();
    observe    = 8'hA4;
    exp_active = 1'b1;
    exp_armed  = 1'b0;
    #1; chk_state("trig2");
    rst_n      = 1'b0;
    ctrl_in    = 8'h33;
    exp_active = 1'b0;
    exp_armed  = 1'b0;
    #1; chk_state("rst_active");
    nxt();
    rst_n = 1'b1;
    nxt(); #1; chk_state("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
